bsg_two_fifo_width_p28: RTL and testbench

Two-entry ready/valid buffer that drains enable-loaded registers toward a downstream consumer. It is the read-side counterpart to our reset/enable data registers: the producer offers words with `v_i`/`ready_o`, and the consumer accepts them with `v_o`/`yumi_i`. It sits at pipeline boundaries where full throughput is needed without a combinational path from `yumi_i` to `ready_o`.

---
 rtl/bsg_two_fifo_pkg.sv | 24 ++
 rtl/bsg_two_fifo_mem.sv | 40 ++++
 rtl/bsg_two_fifo_width_p28.sv | 90 +++++++++
 tb/tb_bsg_two_fifo_width_p28.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bsg_two_fifo_pkg.sv
// Shared types and constants for the two-entry ready/valid buffer.
// Used by bsg_two_fifo_mem and bsg_two_fifo_width_p28.
package bsg_two_fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } bsg_two_fifo_state_e;

  localparam int bsg_two_fifo_els_gp = 2;
  localparam int bsg_two_fifo_count_width_gp = 2;

  function automatic logic [1:0] state_count(
    bsg_two_fifo_state_e s
  );
    unique case (s)
      FULL:    return 2'd2;
      ONE:     return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/bsg_two_fifo_mem.sv
// Two-entry storage: per-entry write enable, read mux on rptr,
// asynchronous active-low clear of both entries.
module bsg_two_fifo_mem
  import bsg_two_fifo_pkg::*;
#(
  parameter int width_p = 28
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               we_i,
  input  logic               wptr_i,
  input  logic               rptr_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] mem_q [bsg_two_fifo_els_gp];
  logic [width_p-1:0] mem_d [bsg_two_fifo_els_gp];

  always_comb begin
    for (int i = 0; i < bsg_two_fifo_els_gp; i++) begin
      mem_d[i] = mem_q[i];
      if (we_i && (wptr_i == 1'(i)))
        mem_d[i] = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < bsg_two_fifo_els_gp; i++)
        mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < bsg_two_fifo_els_gp; i++)
        mem_q[i] <= mem_d[i];
    end
  end

  assign data_o = mem_q[rptr_i];

endmodule

// File: rtl/bsg_two_fifo_width_p28.sv
// Two-entry ready/valid buffer, 28-bit words, registered handshakes.
// Optional occupancy output count_o under BSG_TWO_FIFO_COUNT_EN.
module bsg_two_fifo_width_p28
  import bsg_two_fifo_pkg::*;
#(
  parameter int width_p = 28
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
`ifdef BSG_TWO_FIFO_COUNT_EN
  ,
  output logic [bsg_two_fifo_count_width_gp-1:0] count_o
`endif
);

  bsg_two_fifo_state_e state_q, state_d;
  logic wptr_q, wptr_d;
  logic rptr_q, rptr_d;
  logic enq, deq;

  // Both handshakes decode only registered state, never v_i/yumi_i.
  assign ready_o = (state_q != FULL) & reset_n_i;
  assign v_o     = (state_q != EMPTY);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_comb begin
    wptr_d  = wptr_q ^ enq;
    rptr_d  = rptr_q ^ deq;
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (enq) state_d = ONE;
      ONE: begin
        if (enq && !deq) state_d = FULL;
        if (deq && !enq) state_d = EMPTY;
      end
      FULL:    if (deq) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= EMPTY;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  bsg_two_fifo_mem #(
    .width_p(width_p)
  ) u_mem (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .we_i     (enq),
    .wptr_i   (wptr_q),
    .rptr_i   (rptr_q),
    .data_i   (data_i),
    .data_o   (data_o)
  );

`ifdef BSG_TWO_FIFO_COUNT_EN
  logic [bsg_two_fifo_count_width_gp-1:0] count_q, count_d;

  assign count_d = state_count(state_d);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) count_q <= '0;
    else            count_q <= count_d;
  end

  assign count_o = count_q;
`endif

  a_yumi_legal: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    yumi_i |-> v_o
  ) else $error("yumi_i asserted while buffer empty");

endmodule

// File: tb/tb_bsg_two_fifo_width_p28.sv
// Bench for bsg_two_fifo_width_p28: queue model checked every
// negedge plus directed literal checks of the key scenarios.
module tb_bsg_two_fifo_width_p28;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v_i;
  logic [27:0] data_i;
  logic        ready_o;
  logic        v_o;
  logic [27:0] data_o;
  logic        yumi_i;
`ifdef BSG_TWO_FIFO_COUNT_EN
  logic [1:0]  count_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bsg_two_fifo_width_p28 dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .v_i      (v_i),
    .data_i   (data_i),
    .ready_o  (ready_o),
    .v_o      (v_o),
    .data_o   (data_o),
    .yumi_i   (yumi_i)
`ifdef BSG_TWO_FIFO_COUNT_EN
    ,
    .count_o  (count_o)
`endif
  );

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t",
               name, got, exp, $time);
    end
  endtask

  // Behavioural model: a bounded queue of at most two words.
  logic [27:0] mq [$];
  bit m_enq, m_deq;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      m_enq = v_i && (mq.size() < 2);
      m_deq = yumi_i && (mq.size() > 0);
      if (m_deq) void'(mq.pop_front());
      if (m_enq) mq.push_back(data_i);
    end
  end

  always @(negedge clk) begin
    chk("m_v_o", 32'(v_o), 32'(mq.size() > 0));
    chk("m_ready_o", 32'(ready_o),
        32'((mq.size() < 2) && rst_n));
    if (mq.size() > 0)
      chk("m_data_o", 32'(data_o), 32'(mq[0]));
`ifdef BSG_TWO_FIFO_COUNT_EN
    chk("m_count_o", 32'(count_o), 32'(mq.size()));
`endif
  end

  task automatic drive(input logic v, input logic [27:0] d,
                       input logic y);
    v_i    = v;
    data_i = d;
    yumi_i = y;
    @(posedge clk);
    #1;
  endtask

  task automatic cnt_chk(input string name, input int exp);
`ifdef BSG_TWO_FIFO_COUNT_EN
    chk(name, 32'(count_o), 32'(exp));
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    v_i    = 1'b1;
    data_i = 28'hABCDEF1;
    yumi_i = 1'b0;
    repeat (3) drive(1'b1, 28'hABCDEF1, 1'b0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_v", 32'(v_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    cnt_chk("rst_count", 0);

    rst_n = 1'b1;
    v_i   = 1'b0;
    #1;
    chk("rel_ready", 32'(ready_o), 32'd1);
    chk("rel_v", 32'(v_o), 32'd0);
    drive(1'b0, 28'h0, 1'b0);
    chk("nothing_stored", 32'(v_o), 32'd0);
    chk("rel_data", 32'(data_o), 32'd0);

    drive(1'b1, 28'h0000001, 1'b0);
    chk("one_v", 32'(v_o), 32'd1);
    chk("one_data", 32'(data_o), 32'h1);
    drive(1'b1, 28'h0000002, 1'b0);
    chk("full_ready", 32'(ready_o), 32'd0);
    chk("full_data", 32'(data_o), 32'h1);
    cnt_chk("full_count", 2);
    repeat (2) drive(1'b1, 28'h0000003, 1'b0);
    chk("held_data", 32'(data_o), 32'h1);
    chk("held_ready", 32'(ready_o), 32'd0);

    drive(1'b1, 28'h0000003, 1'b1);
    chk("pop_data", 32'(data_o), 32'h2);
    chk("pop_ready", 32'(ready_o), 32'd1);
    cnt_chk("pop_count", 1);
    drive(1'b1, 28'h0000003, 1'b0);
    chk("wrap_full", 32'(ready_o), 32'd0);
    drive(1'b0, 28'h0, 1'b1);
    chk("wrap_data", 32'(data_o), 32'h3);
    drive(1'b0, 28'h0, 1'b1);
    chk("drain_v", 32'(v_o), 32'd0);

    drive(1'b1, 28'h10, 1'b0);
    for (int i = 1; i < 16; i++) begin
      chk("stream_head", 32'(data_o), 32'(28'h10 + i - 1));
      drive(1'b1, 28'(28'h10 + i), 1'b1);
      chk("stream_v", 32'(v_o), 32'd1);
      chk("stream_ready", 32'(ready_o), 32'd1);
      cnt_chk("stream_count", 1);
    end
    chk("stream_last", 32'(data_o), 32'h1F);
    drive(1'b0, 28'h0, 1'b1);
    chk("stream_empty", 32'(v_o), 32'd0);

    drive(1'b1, 28'hA1, 1'b0);
    drive(1'b1, 28'hA2, 1'b0);
    v_i = 1'b0;
    chk("pre_rst_full", 32'(ready_o), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_v", 32'(v_o), 32'd0);
    chk("async_data", 32'(data_o), 32'd0);
    chk("async_ready", 32'(ready_o), 32'd0);
    cnt_chk("async_count", 0);
    drive(1'b0, 28'h0, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 28'h0, 1'b0);
    chk("post_rst_v", 32'(v_o), 32'd0);
    chk("post_rst_ready", 32'(ready_o), 32'd1);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
